// File: rtl/audio_channel_mixer.sv
// Mono mixer: per-channel unsigned gain, one shared MAC,
// round-half-up, saturate to signed 16 bits.
module audio_channel_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int GAIN_WIDTH   = 8,
  parameter int GAIN_FRAC    = 7
) (
  input  logic                             clk,
  input  logic                             I_RSTn,
  input  logic                             audio_clk_en,
  input  logic [16*NUM_CHANNELS-1:0]       in,
  input  logic [GAIN_WIDTH*NUM_CHANNELS-1:0] gain,
  output logic signed [15:0]               out,
  output logic                             out_valid,
  output logic                             overrun
);

  localparam int PW = 16 + GAIN_WIDTH + 1;
  localparam int AW = PW + $clog2(NUM_CHANNELS);
  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [IW-1:0] LAST = IW'(NUM_CHANNELS - 1);
  localparam logic signed [AW:0] RND  = (AW+1)'(1 << (GAIN_FRAC - 1));
  localparam logic signed [AW:0] MAXV = (AW+1)'(32767);
  localparam logic signed [AW:0] MINV = -(AW+1)'(32768);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                  state;
  logic [IW-1:0]               idx;
  logic signed [AW-1:0]        acc;
  logic signed [15:0]          snap_in   [NUM_CHANNELS];
  logic [GAIN_WIDTH-1:0]       snap_gain [NUM_CHANNELS];

  logic signed [PW-1:0] prod;
  logic signed [AW:0]   sum;
  logic signed [AW:0]   res;

  // Gain is zero-extended so it stays non-negative in the signed multiply.
  always_comb begin
    prod = snap_in[idx] * $signed({1'b0, snap_gain[idx]});
    sum  = {acc[AW-1], acc} + RND;
    res  = sum >>> GAIN_FRAC;
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        snap_in[k]   <= '0;
        snap_gain[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (audio_clk_en && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (audio_clk_en) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
              snap_in[k]   <= in[16*k +: 16];
              snap_gain[k] <= gain[GAIN_WIDTH*k +: GAIN_WIDTH];
            end
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + {{(AW-PW){prod[PW-1]}}, prod};
          idx <= idx + 1'b1;
          if (idx == LAST)
            state <= DONE;
        end
        DONE: begin
          if (res > MAXV)
            out <= 16'sh7fff;
          else if (res < MINV)
            out <= -16'sh8000;
          else
            out <= res[15:0];
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_channel_mixer.sv
// Directed bench for audio_channel_mixer with
// hand-computed expected mixes.
module tb_audio_channel_mixer;

  logic               clk = 1'b0;
  logic               I_RSTn = 1'b0;
  logic               audio_clk_en = 1'b0;
  logic [63:0]        in = '0;
  logic [31:0]        gain = '0;
  logic signed [15:0] out;
  logic               out_valid;
  logic               overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int last_out = 0;
  int last_cyc = 0;
  int t0 = 0;
  int bad = 0;

  audio_channel_mixer dut (
    .clk(clk),
    .I_RSTn(I_RSTn),
    .audio_clk_en(audio_clk_en),
    .in(in),
    .gain(gain),
    .out(out),
    .out_valid(out_valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      last_out = int'(out);
      last_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] gk(input int a, input int b,
                                     input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic mix(input string tag, input logic [63:0] iv,
                     input logic [31:0] gv, input int exp);
    pulses = 0;
    @(negedge clk);
    in = iv;
    gain = gv;
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    t0 = cyc;
    repeat (10) @(negedge clk);
    chk({tag, "_out"}, last_out, exp);
    chk({tag, "_lat"}, last_cyc - t0, 5);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_hold"}, int'(out), exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovr", int'(overrun), 0);
    I_RSTn = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (out !== 16'sd0 || out_valid !== 1'b0 || overrun !== 1'b0)
        bad++;
    end
    chk("idle_bad_cycles", bad, 0);

    mix("unity", pk(1000, 0, 0, 0), gk(128, 128, 128, 128), 1000);
    mix("weighted", pk(3, -200, 32767, 0), gk(64, 128, 0, 255), -198);
    mix("mute", pk(0, 0, 32767, 0), gk(128, 128, 0, 128), 0);
    mix("round", pk(1, 0, 0, 0), gk(64, 0, 0, 0), 1);
    mix("sat_pos", pk(30000, 30000, 30000, 30000),
        gk(255, 255, 255, 255), 32767);
    mix("sat_neg", pk(-30000, -30000, -30000, -30000),
        gk(255, 255, 255, 255), -32768);
    chk("no_ovr_yet", int'(overrun), 0);

    pulses = 0;
    @(negedge clk);
    in = pk(500, 0, 0, 0);
    gain = gk(128, 0, 0, 0);
    audio_clk_en = 1'b1;
    @(negedge clk);
    t0 = cyc;
    audio_clk_en = 1'b0;
    in = pk(-7, 0, 0, 0);
    @(negedge clk);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    repeat (12) @(negedge clk);
    chk("ovr_out", last_out, 500);
    chk("ovr_lat", last_cyc - t0, 5);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_flag", int'(overrun), 1);
    repeat (20) @(negedge clk);
    chk("ovr_sticky", int'(overrun), 1);

    pulses = 0;
    @(negedge clk);
    in = pk(1234, 0, 0, 0);
    gain = gk(128, 0, 0, 0);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(negedge clk);
    I_RSTn = 1'b0;
    repeat (2) @(negedge clk);
    I_RSTn = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_pulses", pulses, 0);
    chk("midrst_out", int'(out), 0);
    chk("midrst_ovr", int'(overrun), 0);
    mix("after_rst", pk(100, 0, 0, 0), gk(128, 0, 0, 0), 100);
    chk("after_rst_ovr", int'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_channel_mixer.md
Name: audio_channel_mixer

Overview:
- Downstream consumer of the per-voice RC high-pass stages.
- Sums NUM_CHANNELS signed 16-bit filtered voice signals into one signed 16-bit mono sample.
- Each channel has its own unsigned gain.
- Uses a single time-multiplexed multiply-accumulate sequenced by a small FSM, once per audio_clk_en, with saturation on the result.
- Its output feeds the board-level audio output path.

Parameters:
- NUM_CHANNELS, 4, number of signed 16-bit inputs mixed; range 2..8.
- GAIN_WIDTH, 8, width of each unsigned per-channel gain.
- GAIN_FRAC, 7, fractional bits of the gain: a gain of 128 is unity, and 255 is about 1.99.

Ports:
- clk, input, 1, system clock.
- I_RSTn, input, 1, reset. One clock; reset is asynchronous and active-low.
- audio_clk_en, input, 1, sample strobe, one clk wide.
- in, input, 16*NUM_CHANNELS, packed signed samples; channel k occupies bits [16k+15:16k].
- gain, input, GAIN_WIDTH*NUM_CHANNELS, packed unsigned gains; channel k occupies bits [GAIN_WIDTH*k+GAIN_WIDTH-1 : GAIN_WIDTH*k].
- out, output reg, 16, signed mixed sample.
- out_valid, output reg, 1, one-clk pulse when out updates.
- overrun, output reg, 1, sticky flag: a strobe arrived while the mixer was busy.

Behaviour:
- Reset (asynchronous, I_RSTn low):
  - out=0, out_valid=0, overrun=0, accumulator=0, channel index=0.
  - FSM goes to IDLE; input/gain snapshot registers cleared.
  - Reset asserted mid-ACCUM aborts the sum; no out_valid is produced for that sample.
- FSM states:
  - IDLE: on audio_clk_en, snapshot all of in and gain, clear the accumulator, set idx=0, go to ACCUM.
  - ACCUM: each clk, acc += snap_in[idx] * $signed({1'b0, snap_gain[idx]}), then idx++. After idx = NUM_CHANNELS-1 is accumulated, go to DONE.
  - DONE: round, shift, saturate, write out, pulse out_valid, return to IDLE.
- Latency:
  - Strobe at cycle T means channels are accumulated at T+1 .. T+NUM_CHANNELS.
  - out and out_valid update at edge T+NUM_CHANNELS+1. With default parameters, that is 5 clks after the strobe edge.
  - out holds its value between updates.
- Snapshot: inputs may change freely after cycle T; the mix uses only the values sampled at T.
- Strobe while not IDLE (ACCUM or DONE):
  - The strobe is ignored; the current sample completes unaffected.
  - overrun is set to 1 and stays set until reset.
  - A strobe in the same cycle the FSM returns to IDLE is also ignored. A new sample starts only when the strobe arrives while the state is already IDLE.
- Arithmetic:
  - Product width is 16+GAIN_WIDTH+1.
  - Accumulator width is product width + clog2(NUM_CHANNELS); it must never wrap internally.
  - Result = (acc + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC, an arithmetic shift with round-half-up.
  - Saturate the result to [-32768, 32767] before assigning out; no wrap-around is permitted.
- Gain 0 mutes a channel exactly: a single channel with gain 0 contributes 0.
- out_valid is high for exactly one clk per accepted strobe and is never high in any other cycle.

Test Plan:
- Reset then idle: hold I_RSTn low, then release with no strobes for 100 clks. Required: out=0, out_valid=0, overrun=0 throughout.
- Unity pass-through: in0=1000, other channels 0, all gains 128, one strobe. Required: out=1000 exactly 5 clks later, out_valid high for 1 clk.
- Weighted sum and rounding: in={ch0=3, ch1=-200, ch2=32767, ch3=0}, gains={64, 128, 0, 255}. The accumulator is 3*64 - 200*128 = -25408. Required: out = (-25408 + 64) >>> 7 = -198.
- Saturation:
  - All in=30000, gains=255: out=32767.
  - All in=-30000, gains=255: out=-32768.
- Overrun and snapshot:
  - Strobe at T with in0=500 (gain 128, others 0); change in0 to -7 at T+1; strobe again at T+2.
  - Required: out=500 at T+5, exactly one out_valid pulse, overrun=1 and held.
- Reset mid-operation: assert I_RSTn low at T+2 after a strobe, release it, then strobe with in0=100 (gain 128, others 0). Required: no out_valid before the second strobe; out=100 after 5 clks; overrun=0.
